// File: rtl/adder_pkg.sv
// Shared constants and geometry helpers for the pipelined carry-select adder.
package adder_pkg;

  localparam int unsigned DEF_WIDTH  = 64;
  localparam int unsigned DEF_SEG    = 8;
  localparam int unsigned DEF_STAGES = 4;

  // Bits resolved per pipeline rank (W_S).
  function automatic int unsigned slice_width(input int unsigned width,
                                              input int unsigned stages);
    return width / stages;
  endfunction

  // Carry-select segments per rank (NSEG_S).
  function automatic int unsigned segs_per_slice(input int unsigned width,
                                                 input int unsigned seg,
                                                 input int unsigned stages);
    return width / (stages * seg);
  endfunction

  function automatic bit geometry_ok(input int unsigned width,
                                     input int unsigned seg,
                                     input int unsigned stages);
    return (stages >= 1) && (seg >= 1) && ((width % (stages * seg)) == 0);
  endfunction

endpackage

// File: rtl/pipe_csel_adder_if.sv
// Valid/ready operand and result bus of the pipelined adder.
interface pipe_csel_adder_if
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/csel_segment.sv
// Combinational carry-select segment: both carry-in cases precomputed, ci picks one.
module csel_segment #(
  parameter int unsigned SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co
);
  logic [SEG:0] w_r0;
  logic [SEG:0] w_r1;

  assign w_r0     = {1'b0, a} + {1'b0, b};
  assign w_r1     = w_r0 + (SEG+1)'(1);
  assign {co, s}  = ci ? w_r1 : w_r0;
endmodule

// File: rtl/pipe_csel_adder.sv
// Fully pipelined carry-select adder/subtractor: input rank, one carry slice per rank,
// registered result/carry/overflow, single global advance for flow control.
module pipe_csel_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned SEG    = DEF_SEG,
  parameter int unsigned STAGES = DEF_STAGES
) (
  input logic               clk,
  input logic               rst_n,
  pipe_csel_adder_if.slave  bus
);
  localparam int unsigned W_S    = slice_width(WIDTH, STAGES);
  localparam int unsigned NSEG_S = segs_per_slice(WIDTH, SEG, STAGES);

  if (!geometry_ok(WIDTH, SEG, STAGES)) begin : g_bad_geometry
    $error("pipe_csel_adder: WIDTH must be a multiple of STAGES*SEG and STAGES >= 1");
  end

  typedef struct packed {
    logic             valid;
    logic             sub;
    logic             carry;
    logic [WIDTH-1:0] a_op;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH-1:0] sum_done;
  } rank_t;

  rank_t            r_rank [STAGES];
  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_adv;
  logic [W_S-1:0]   w_slice_sum [STAGES];
  logic             w_slice_co  [STAGES];
  logic [WIDTH-1:0] w_final_sum;
  logic             w_final_ovf;

  assign w_adv        = !r_out_valid || bus.out_ready;
  assign bus.in_ready = w_adv;

  // Rank g resolves bit slice g from the carry it holds.
  for (genvar g = 0; g < STAGES; g++) begin : g_slice
    for (genvar s = 0; s < NSEG_S; s++) begin : g_seg
      logic w_ci;
      logic w_co;
      if (s == 0) begin : g_first
        assign w_ci = r_rank[g].carry;
      end else begin : g_next
        assign w_ci = g_seg[s-1].w_co;
      end
      csel_segment #(.SEG(SEG)) u_seg (
        .a  (r_rank[g].a_op[g*W_S + s*SEG +: SEG]),
        .b  (r_rank[g].b_op[g*W_S + s*SEG +: SEG]),
        .ci (w_ci),
        .s  (w_slice_sum[g][s*SEG +: SEG]),
        .co (w_co)
      );
    end
    assign w_slice_co[g] = g_seg[NSEG_S-1].w_co;
  end

  always_comb begin
    w_final_sum = r_rank[STAGES-1].sum_done;
    w_final_sum[(STAGES-1)*W_S +: W_S] = w_slice_sum[STAGES-1];
    w_final_ovf = (r_rank[STAGES-1].a_op[WIDTH-1] == r_rank[STAGES-1].b_op[WIDTH-1]) &&
                  (w_final_sum[WIDTH-1] != r_rank[STAGES-1].a_op[WIDTH-1]);
  end

  // Every rank moves together on w_adv; output data is forced to zero for bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        r_rank[i] <= '0;
      end
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_adv) begin
      r_rank[0].valid    <= bus.in_valid;
      r_rank[0].sub      <= bus.sub;
      r_rank[0].carry    <= bus.sub ? ~bus.cin : bus.cin;
      r_rank[0].a_op     <= bus.a;
      r_rank[0].b_op     <= bus.sub ? ~bus.b : bus.b;
      r_rank[0].sum_done <= '0;
      for (int unsigned i = 1; i < STAGES; i++) begin
        r_rank[i]                                <= r_rank[i-1];
        r_rank[i].sum_done[(i-1)*W_S +: W_S]     <= w_slice_sum[i-1];
        r_rank[i].carry                          <= w_slice_co[i-1];
      end
      r_out_valid <= r_rank[STAGES-1].valid;
      if (r_rank[STAGES-1].valid) begin
        r_sum  <= w_final_sum;
        r_cout <= w_slice_co[STAGES-1];
        r_ovf  <= w_final_ovf;
      end else begin
        r_sum  <= '0;
        r_cout <= 1'b0;
        r_ovf  <= 1'b0;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
endmodule
